// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state type and the baud divisor helper
// (also intended for reuse by the receive side).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Clock cycles per bit, truncated toward zero.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..DIV-1 while enabled and pulses tick on DIV-1.
// clear restarts the count so every frame begins on a fresh bit boundary.
module baud_tick_gen #(
    parameter int  DIV = 10,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic          tick,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_top_s;

    assign at_top_s = (cnt_q == CW'(DIV - 1));
    assign tick     = en & at_top_s;
    assign cnt      = cnt_q;

    // Next count: clear wins, otherwise wrap at DIV-1 while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            if (at_top_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed from a show-ahead FIFO. Pops one byte per frame,
// either from IDLE or in the final stop cycle so frames run back-to-back.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] rdata,
    output logic       pop,
    output logic       tx,
    output logic       tx_busy
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_t     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q,   bit_d;
    logic          tx_q,    tx_d;
    logic          busy_q,  busy_d;
    logic          pop_s;
    logic          tick_s;
    logic          stop_last_s;
    logic [CW-1:0] baud_cnt_s;

    baud_tick_gen #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (pop_s),
        .en    (state_q != IDLE),
        .tick  (tick_s),
        .cnt   (baud_cnt_s)
    );

    assign stop_last_s = (baud_cnt_s == CW'(DIV - 1));
    // Pop is held off while reset is asserted so the FIFO never loses a byte
    // to a frame that cannot start.
    assign pop     = pop_s & ~rst;
    assign tx      = tx_q;
    assign tx_busy = busy_q;

    // Next-state, shift/bit-counter update and FIFO pop decision.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop_s   = 1'b1;
                    shift_d = rdata;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (stop_last_s) begin
                    if (!empty) begin
                        pop_s   = 1'b1;
                        shift_d = rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level and busy flag for the cycle the next state is entered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        case (state_d)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = shift_d[0];
                busy_d = 1'b1;
            end
            STOP: begin
                tx_d   = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= 8'h00;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx at DIV=10: behavioural frame-position model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_uart_tx;

    localparam int DIV   = 1000 / 100;
    localparam int FRAME = 10 * DIV;
    localparam int LOGSZ = 65536;

    logic       clk;
    logic       rst;
    logic       empty;
    logic [7:0] rdata;
    logic       pop;
    logic       tx;
    logic       tx_busy;

    uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk     (clk),
        .rst     (rst),
        .empty   (empty),
        .rdata   (rdata),
        .pop     (pop),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] fifo[$];
    int         pop_cycles[$];
    bit         tx_log   [0:LOGSZ-1];
    bit         busy_log [0:LOGSZ-1];
    bit         pop_at_neg = 1'b0;

    // Model: whether a frame is in flight, its byte and position 0..FRAME-1.
    bit         m_busy = 1'b0;
    int         m_pos  = 0;
    logic [7:0] m_byte = 8'h00;
    logic       exp_pop, exp_tx, exp_busy;
    int         bi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: predict outputs from frame position, check, advance.
    initial begin
        forever begin
            @(negedge clk);
            exp_pop  = 1'b0;
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            if (!rst) begin
                exp_busy = m_busy;
                if (m_busy) begin
                    bi = m_pos / DIV;
                    if (bi == 0)      exp_tx = 1'b0;
                    else if (bi == 9) exp_tx = 1'b1;
                    else              exp_tx = m_byte[bi-1];
                end
                exp_pop = !empty && (!m_busy || m_pos == FRAME - 1);
            end
            chk("pop", {31'd0, pop}, {31'd0, exp_pop});
            chk("tx", {31'd0, tx}, {31'd0, exp_tx});
            chk("tx_busy", {31'd0, tx_busy}, {31'd0, exp_busy});
            chk("pop_while_empty", {31'd0, pop & empty}, 32'd0);
            if (cyc < LOGSZ) begin
                tx_log[cyc]   = tx;
                busy_log[cyc] = tx_busy;
            end
            if (pop) pop_cycles.push_back(cyc);
            pop_at_neg = pop;
            if (rst) begin
                m_busy = 1'b0;
            end else if (exp_pop) begin
                m_busy = 1'b1;
                m_pos  = 0;
                m_byte = rdata;
            end else if (m_busy) begin
                if (m_pos == FRAME - 1) m_busy = 1'b0;
                else                    m_pos++;
            end
            cyc++;
        end
    end

    task automatic drive_fifo();
        empty = (fifo.size() == 0);
        rdata = (fifo.size() == 0) ? 8'h00 : fifo[0];
    endtask

    task automatic tick();
        logic [7:0] tmp;
        @(posedge clk);
        #1;
        if (pop_at_neg && fifo.size() > 0) tmp = fifo.pop_front();
        drive_fifo();
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        drive_fifo();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic int pc(input int i);
        if (i >= 0 && i < pop_cycles.size()) return pop_cycles[i];
        return -1;
    endfunction

    // Independent line decoder: mid-bit samples relative to the pop cycle.
    function automatic logic [7:0] decode(input int p);
        logic [7:0] v;
        v = 8'h00;
        if (p >= 0 && p + FRAME < LOGSZ)
            for (int k = 0; k < 8; k++) v[k] = tx_log[p + 1 + (k + 1) * DIV + DIV / 2];
        return v;
    endfunction

    function automatic int count_busy(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) if (i >= 0 && i < LOGSZ && busy_log[i]) n++;
        return n;
    endfunction

    initial begin
        int t, t2, base, n0, pushed, start, n, zeros;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        bit exp_bits [0:9];

        rst = 1'b0;
        empty = 1'b1;
        rdata = 8'h00;
        #1 rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;

        // Idle after reset release.
        t = cyc;
        wait_until(t + 50);
        chk("idle_pops", pop_cycles.size(), 32'd0);
        chk("idle_busy", count_busy(t, t + 49), 32'd0);
        chk("idle_tx", {31'd0, tx}, 32'd1);

        // Single byte 0x41.
        base = pop_cycles.size();
        push(8'h41);
        t = cyc;
        wait_until(t + 115);
        chk("b41_pops", pop_cycles.size() - base, 32'd1);
        chk("b41_pop_cycle", pc(base), t);
        chk("b41_busy_len", count_busy(t, t + 110), 32'd100);
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 10; k++)
            chk("b41_bit", {31'd0, tx_log[t + 1 + k * DIV + DIV / 2]}, {31'd0, exp_bits[k]});

        // Three preloaded bytes, back to back.
        base = pop_cycles.size();
        fifo.push_back(8'h55);
        fifo.push_back(8'h00);
        push(8'hFF);
        t = cyc;
        wait_until(t + 320);
        chk("b3_pops", pop_cycles.size() - base, 32'd3);
        chk("b3_gap1", pc(base + 1) - pc(base), 32'd100);
        chk("b3_gap2", pc(base + 2) - pc(base + 1), 32'd100);
        chk("b3_busy_len", count_busy(t, t + 310), 32'd300);
        chk("b3_contig", count_busy(t + 1, t + 300), 32'd300);
        chk("b3_byte0", decode(pc(base)), 32'h55);
        chk("b3_byte1", decode(pc(base + 1)), 32'h00);
        chk("b3_byte2", decode(pc(base + 2)), 32'hFF);

        // Refill during DATA bit 4, then one cycle after the stop bit ends.
        base = pop_cycles.size();
        push(8'h30);
        t = cyc;
        wait_until(t + 55);
        push(8'h31);
        wait_until(t + 201);
        push(8'h32);
        wait_until(t + 320);
        chk("rf_pops", pop_cycles.size() - base, 32'd3);
        chk("rf_pop0", pc(base), t);
        chk("rf_pop1", pc(base + 1), t + 100);
        chk("rf_pop2", pc(base + 2), t + 201);
        chk("rf_gap_busy", {31'd0, busy_log[t + 201]}, 32'd0);
        chk("rf_gap_tx", {31'd0, tx_log[t + 201]}, 32'd1);
        chk("rf_byte0", decode(pc(base)), 32'h30);
        chk("rf_byte1", decode(pc(base + 1)), 32'h31);
        chk("rf_byte2", decode(pc(base + 2)), 32'h32);

        // Reset during DATA bit 3 of 0xA5.
        base = pop_cycles.size();
        push(8'hA5);
        t = cyc;
        wait_until(t + 45);
        chk("rs_pre_tx", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rs_async_tx", {31'd0, tx}, 32'd1);
        chk("rs_async_busy", {31'd0, tx_busy}, 32'd0);
        chk("rs_async_pop", {31'd0, pop}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        n0 = pop_cycles.size();
        t2 = cyc;
        wait_until(t2 + 50);
        chk("rs_no_resend", pop_cycles.size() - n0, 32'd0);
        chk("rs_idle_busy", count_busy(t2, t2 + 49), 32'd0);
        push(8'h5A);
        t2 = cyc;
        wait_until(t2 + 110);
        chk("rs_next_pop", pc(base + 1), t2);
        zeros = 0;
        for (int i = 1; i <= DIV; i++) if (!tx_log[t2 + i]) zeros++;
        chk("rs_start_len", zeros, DIV);
        chk("rs_byte", decode(t2), 32'h5A);

        // Random traffic: 256 bytes with random gaps and bursts.
        base = pop_cycles.size();
        pushed = 0;
        start = cyc;
        while (pushed < 256 && cyc < start + 45000) begin
            if ($urandom_range(0, 149) == 0) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n && pushed < 256; i++) begin
                    b = 8'($urandom_range(0, 255));
                    exp_q.push_back(b);
                    push(b);
                    pushed++;
                end
            end
            tick();
        end
        chk("rnd_all_pushed", pushed, 32'd256);
        while ((fifo.size() != 0 || tx_busy) && cyc < start + 70000) tick();
        chk("rnd_drained", {31'd0, tx_busy}, 32'd0);
        wait_until(cyc + 5);
        chk("rnd_pops", pop_cycles.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk("rnd_byte", decode(pc(base + i)), {24'd0, exp_q[i]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
